// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply/divide unit owning the HI/LO register pair.
//   mul: shift-add, one bit per cycle. div: restoring shift-subtract, one bit per cycle.
//   Accept at edge N, iterate on edges N+1..N+WIDTH, load hi/lo with done=1 on edge N+WIDTH+1.
//   Divide by zero short-cuts through ZDIV: lo=all ones, hi=dividend, dz=1 on edge N+1.
// Optional feature macro: MULDIV_SIGNED_EN (op[1]=1 selects signed operation; magnitudes
//   are iterated and signs are fixed up while loading the result).
module muldiv_iter #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] HI_RST = WIDTH'(32'h32),
  parameter logic [WIDTH-1:0] LO_RST = WIDTH'(32'h16)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    ZDIV = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic             op_div;
  // acc: running upper product half (mul) or partial remainder (div)
  // low: multiplier bits shifted out (mul) or dividend/quotient shift register (div)
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] opnd;

  logic             accept;
  logic             zero_div;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH-1:0] mul_low_nxt;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] div_acc_nxt;
  logic [WIDTH-1:0] div_low_nxt;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign zero_div = op[0] && (b == '0);

`ifdef MULDIV_SIGNED_EN
  logic                 neg_a_in;
  logic                 neg_b_in;
  logic                 neg_q;
  logic                 neg_r;
  logic [2*WIDTH-1:0]   prod_raw;

  assign neg_a_in = op[1] & a[WIDTH-1];
  assign neg_b_in = op[1] & b[WIDTH-1];
  assign a_mag    = neg_a_in ? -a : a;
  assign b_mag    = neg_b_in ? -b : b;
  assign prod_raw = {acc, low};

  // Sign correction of the iterated magnitudes during the load cycle
  always_comb begin
    res_hi = acc;
    res_lo = low;
    if (!op_div) begin
      if (neg_q) {res_hi, res_lo} = -prod_raw;
    end else begin
      if (neg_q) res_lo = -low;
      if (neg_r) res_hi = -acc;
    end
  end

  // Result sign flags captured at accept; remainder follows the dividend
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= neg_a_in ^ neg_b_in;
      neg_r <= neg_a_in & op[0];
    end
  end
`else
  logic unused_op_sign;

  assign unused_op_sign = op[1];
  assign a_mag          = a;
  assign b_mag          = b;
  assign res_hi         = acc;
  assign res_lo         = low;
`endif

  // Next-state and handshake decode
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt = state;
    accept    = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = zero_div ? ZDIV : RUN;
        end
      end
      RUN:     if (cnt == LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      ZDIV:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // One iteration step for each operation
  always_comb begin
    mul_sum     = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
    mul_acc_nxt = mul_sum[WIDTH:1];
    mul_low_nxt = {mul_sum[0], low[WIDTH-1:1]};
    div_shift   = {acc, low[WIDTH-1]};
    div_diff    = div_shift - {1'b0, opnd};
    if (!div_diff[WIDTH]) begin
      div_acc_nxt = div_diff[WIDTH-1:0];
      div_low_nxt = {low[WIDTH-2:0], 1'b1};
    end else begin
      div_acc_nxt = div_shift[WIDTH-1:0];
      div_low_nxt = {low[WIDTH-2:0], 1'b0};
    end
  end

  // Datapath: operand capture, iteration, result load and direct hi/lo writes
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_div <= 1'b0;
      acc    <= '0;
      low    <= '0;
      opnd   <= '0;
      hi     <= HI_RST;
      lo     <= LO_RST;
      done   <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      // Result loads only happen in busy states, so they never collide with mthi/mtlo
      if (!busy) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            op_div <= op[0];
            acc    <= '0;
            low    <= zero_div ? a : a_mag;
            opnd   <= b_mag;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op_div) begin
            acc <= div_acc_nxt;
            low <= div_low_nxt;
          end else begin
            acc <= mul_acc_nxt;
            low <= mul_low_nxt;
          end
        end
        FIN: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        ZDIV: begin
          hi   <= low;
          lo   <= '1;
          done <= 1'b1;
          dz   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter (WIDTH=32).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_muldiv_iter;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_SMUL = 2'b10;
  localparam logic [1:0] OP_SDIV = 2'b11;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests_run;
  int tests_failed;

  muldiv_iter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present an operation for one accept edge; returns at the falling edge after accept
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit hold);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Wait (bounded) for done; lat counts falling edges after the accept edge
  task automatic wait_done(input int pulse_at, output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (pulse_at >= 0 && lat == pulse_at) begin
        start = 1'b1; op = OP_MUL; a = 32'd1; b = 32'd1;
      end
      if (pulse_at >= 0 && lat == pulse_at + 1) start = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests_run++; if (hi !== 32'h32) begin tests_failed++; $display("FAIL reset_hi: got %h want %h", hi, 32'h32); end
    tests_run++; if (lo !== 32'h16) begin tests_failed++; $display("FAIL reset_lo: got %h want %h", lo, 32'h16); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++; if (dz !== 1'b0) begin tests_failed++; $display("FAIL reset_dz: got %b want 0", dz); end
  endtask

  task automatic test_mul_max();
    int lat;
    bit busy_ok;
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(-1, lat, busy_ok);
    tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL mul_latency: got %0d want 33", lat); end
    tests_run++; if (busy_ok !== 1'b1) begin tests_failed++; $display("FAIL mul_busy_run: got %b want 1", busy_ok); end
    tests_run++; if (hi !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL mul_max_hi: got %h want %h", hi, 32'hFFFF_FFFE); end
    tests_run++; if (lo !== 32'h0000_0001) begin tests_failed++; $display("FAIL mul_max_lo: got %h want %h", lo, 32'h1); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mul_busy_done: got %b want 0", busy); end
    @(negedge clk);
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL mul_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_div();
    int lat;
    bit busy_ok;
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    wait_done(10, lat, busy_ok);
    tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL div_latency: got %0d want 33", lat); end
    tests_run++; if (busy_ok !== 1'b1) begin tests_failed++; $display("FAIL div_busy_run: got %b want 1", busy_ok); end
    tests_run++; if (hi !== 32'h2) begin tests_failed++; $display("FAIL div_rem: got %h want %h", hi, 32'h2); end
    tests_run++; if (lo !== 32'hE) begin tests_failed++; $display("FAIL div_quot: got %h want %h", lo, 32'hE); end
    tests_run++; if (dz !== 1'b0) begin tests_failed++; $display("FAIL div_dz: got %b want 0", dz); end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL div_ignored_start: busy got %b want 0", busy); end
  endtask

  task automatic test_div_zero();
    int lat;
    bit busy_ok;
    issue(OP_DIV, 32'd5, 32'd0, 1'b0);
    wait_done(-1, lat, busy_ok);
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL dz_latency: got %0d want 1", lat); end
    tests_run++; if (busy_ok !== 1'b1) begin tests_failed++; $display("FAIL dz_busy: got %b want 1", busy_ok); end
    tests_run++; if (lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL dz_lo: got %h want %h", lo, 32'hFFFF_FFFF); end
    tests_run++; if (hi !== 32'h5) begin tests_failed++; $display("FAIL dz_hi: got %h want %h", hi, 32'h5); end
    tests_run++; if (dz !== 1'b1) begin tests_failed++; $display("FAIL dz_flag: got %b want 1", dz); end
    @(negedge clk);
    tests_run++; if (dz !== 1'b0) begin tests_failed++; $display("FAIL dz_clear: got %b want 0", dz); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL dz_done_clear: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit busy_ok;
    issue(OP_MUL, 32'd3, 32'd4, 1'b1);
    wait_done(-1, lat, busy_ok);
    tests_run++; if (lo !== 32'hC) begin tests_failed++; $display("FAIL b2b_first_lo: got %h want %h", lo, 32'hC); end
    a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_no_gap: busy got %b want 1", busy); end
    wait_done(-1, lat, busy_ok);
    tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    tests_run++; if (lo !== 32'h2A) begin tests_failed++; $display("FAIL b2b_second_lo: got %h want %h", lo, 32'h2A); end
    tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL b2b_second_hi: got %h want 0", hi); end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    tests_run++; if (hi !== 32'h32) begin tests_failed++; $display("FAIL rstmid_hi: got %h want %h", hi, 32'h32); end
    tests_run++; if (lo !== 32'h16) begin tests_failed++; $display("FAIL rstmid_lo: got %h want %h", lo, 32'h16); end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    tests_run++; if (saw_done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_done: got %b want 0", saw_done); end
  endtask

  task automatic test_direct_write();
    int lat;
    bit busy_ok;
    @(negedge clk);
    wr_lo = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    wr_lo = 1'b0;
    tests_run++; if (lo !== 32'hABCD) begin tests_failed++; $display("FAIL wr_lo_idle: got %h want %h", lo, 32'hABCD); end
    tests_run++; if (hi !== 32'h32) begin tests_failed++; $display("FAIL wr_lo_hi_kept: got %h want %h", hi, 32'h32); end
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h55AA;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    tests_run++; if (hi !== 32'h55AA) begin tests_failed++; $display("FAIL wr_both_hi: got %h want %h", hi, 32'h55AA); end
    tests_run++; if (lo !== 32'h55AA) begin tests_failed++; $display("FAIL wr_both_lo: got %h want %h", lo, 32'h55AA); end
    // start together with mthi: the write lands, the result later overwrites it
    op = OP_MUL; a = 32'd2; b = 32'd3; start = 1'b1; wr_hi = 1'b1; wdata = 32'h77;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    tests_run++; if (hi !== 32'h77) begin tests_failed++; $display("FAIL wr_with_start: got %h want %h", hi, 32'h77); end
    wr_lo = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    wr_lo = 1'b0;
    tests_run++; if (lo !== 32'h55AA) begin tests_failed++; $display("FAIL wr_lo_busy: got %h want %h", lo, 32'h55AA); end
    wait_done(-1, lat, busy_ok);
    tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL wr_overwrite_hi: got %h want 0", hi); end
    tests_run++; if (lo !== 32'h6) begin tests_failed++; $display("FAIL wr_overwrite_lo: got %h want %h", lo, 32'h6); end
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed();
    int lat;
    bit busy_ok;
    issue(OP_SDIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done(-1, lat, busy_ok);
    tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL sdiv_latency: got %0d want 33", lat); end
    tests_run++; if (lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL sdiv_quot: got %h want %h", lo, 32'hFFFF_FFFD); end
    tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL sdiv_rem: got %h want %h", hi, 32'hFFFF_FFFF); end
    issue(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done(-1, lat, busy_ok);
    tests_run++; if (lo !== 32'h8000_0000) begin tests_failed++; $display("FAIL sdiv_ovf_quot: got %h want %h", lo, 32'h8000_0000); end
    tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL sdiv_ovf_rem: got %h want 0", hi); end
    tests_run++; if (dz !== 1'b0) begin tests_failed++; $display("FAIL sdiv_ovf_dz: got %b want 0", dz); end
    issue(OP_SMUL, 32'hFFFF_FFFD, 32'd4, 1'b0);
    wait_done(-1, lat, busy_ok);
    tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL smul_hi: got %h want %h", hi, 32'hFFFF_FFFF); end
    tests_run++; if (lo !== 32'hFFFF_FFF4) begin tests_failed++; $display("FAIL smul_lo: got %h want %h", lo, 32'hFFFF_FFF4); end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = OP_MUL;
    a     = '0;
    b     = '0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    wdata = '0;
    test_reset();
    test_mul_max();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_direct_write();
`ifdef MULDIV_SIGNED_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
